// File: rtl/rover_pkg.sv
// Shared types and constants for the rover drive controller: state encoding,
// status-LED codes and duty-fraction helpers.
package rover_pkg;

   localparam int unsigned CLK_HZ  = 100_000_000;
   localparam int          DWELL_W = 26;
   localparam int          LED_W   = 3;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FWD      = 3'd1,
      S_BRAKE    = 3'd2,
      S_REV      = 3'd3,
      S_TURN2BRK = 3'd4,
      S_TURN     = 3'd5,
      S_FAULT    = 3'd6
   } state_t;

   localparam logic [LED_W-1:0] LED_IDLE  = 3'd0;
   localparam logic [LED_W-1:0] LED_FWD   = 3'd1;
   localparam logic [LED_W-1:0] LED_BRAKE = 3'd2;
   localparam logic [LED_W-1:0] LED_REV   = 3'd3;
   localparam logic [LED_W-1:0] LED_TURN  = 3'd4;
   localparam logic [LED_W-1:0] LED_FAULT = 3'd5;

   // Forward duty is (sel+1)/4 of a frame; reverse and pivot run at 1/2.
   localparam int unsigned FWD_DUTY_DEN  = 4;
   localparam int unsigned HALF_DUTY_NUM = 1;
   localparam int unsigned HALF_DUTY_DEN = 2;

   function automatic int unsigned duty_frac(input int unsigned period,
                                             input int unsigned num,
                                             input int unsigned den);
      return (period * num) / den;
   endfunction

   // Both brake dwells share one LED code.
   function automatic logic [LED_W-1:0] state_led_of(input state_t s);
      case (s)
         S_FWD:              return LED_FWD;
         S_BRAKE, S_TURN2BRK: return LED_BRAKE;
         S_REV:              return LED_REV;
         S_TURN:             return LED_TURN;
         S_FAULT:            return LED_FAULT;
         default:            return LED_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/rover_motor_ctrl_if.sv
// Control inputs and H-bridge/status outputs of the rover drive controller.
interface rover_motor_ctrl_if;
   import rover_pkg::*;

   logic             enable;
   logic             is_crash;
   logic [1:0]       speed_sel;
   logic             l_fwd;
   logic             l_rev;
   logic             r_fwd;
   logic             r_rev;
   logic             pwm_l;
   logic             pwm_r;
   logic [LED_W-1:0] state_led;
   logic             fault;

   modport master (
      output enable, is_crash, speed_sel,
      input  l_fwd, l_rev, r_fwd, r_rev, pwm_l, pwm_r, state_led, fault
   );

   modport slave (
      input  enable, is_crash, speed_sel,
      output l_fwd, l_rev, r_fwd, r_rev, pwm_l, pwm_r, state_led, fault
   );

endinterface

// File: rtl/pwm_gen.sv
// Free-running PWM frame counter shared by CH channels; each channel's duty
// is re-latched only at frame wrap so duty changes never split a frame.
module pwm_gen #(
   parameter int unsigned PERIOD = 5000,
   parameter int          CH     = 2,
   parameter int          W      = $clog2(PERIOD + 1)
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [CH-1:0][W-1:0]  target,
   input  logic [CH-1:0]         active,
   output logic [CH-1:0]         pwm
);

   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt_reg;
   logic [W-1:0] duty_reg [CH];

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
         if (srst) begin
            duty_reg[gi] <= '0;
         end else if (cnt_reg == LAST) begin
            duty_reg[gi] <= target[gi];
         end
      end

      assign pwm[gi] = active[gi] && (cnt_reg < duty_reg[gi]);
   end

endmodule

// File: rtl/rover_motor_ctrl.sv
// Rover drive sequencer: forward cruise, filtered crash response
// (brake, reverse, brake, pivot), retry limit with latched fault.
module rover_motor_ctrl
   import rover_pkg::*;
#(
   parameter int unsigned PWM_PERIOD     = 5000,
   parameter int unsigned CRASH_FILT_CYC = 100000,
   parameter int unsigned BRAKE_CYC      = 10000000,
   parameter int unsigned REV_CYC        = 50000000,
   parameter int unsigned TURN_CYC       = 40000000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic               clk,
   input  logic               reset,
   rover_motor_ctrl_if.slave  bus
);

   localparam int PW = $clog2(PWM_PERIOD + 1);
   localparam int FW = $clog2(CRASH_FILT_CYC + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   localparam logic [FW-1:0]      FILT_MAX   = FW'(CRASH_FILT_CYC);
   localparam logic [RW-1:0]      RETRY_MAX  = RW'(MAX_RETRY);
   localparam logic [DWELL_W-1:0] BRAKE_LOAD = DWELL_W'(BRAKE_CYC - 1);
   localparam logic [DWELL_W-1:0] REV_LOAD   = DWELL_W'(REV_CYC - 1);
   localparam logic [DWELL_W-1:0] TURN_LOAD  = DWELL_W'(TURN_CYC - 1);
   localparam logic [PW-1:0]      DUTY_HALF  =
      PW'(duty_frac(PWM_PERIOD, HALF_DUTY_NUM, HALF_DUTY_DEN));

   state_t             state_reg, state_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic [RW-1:0]      retry_reg, retry_next;
   logic [FW-1:0]      filt_reg;
   logic               crash_q_reg;
   logic [3:0]         pins_reg, pins_next;   // {l_fwd, l_rev, r_fwd, r_rev}
   logic [LED_W-1:0]   led_reg;
   logic               fault_reg;
   logic               brake_req;
   logic               dwell_done;

   logic [PW-1:0]      fwd_duty [4];
   logic [PW-1:0]      duty_sel;
   logic [1:0][PW-1:0] duty_target;
   logic [1:0]         pwm_active;
   logic [1:0]         pwm_raw;
   logic               braking;

   for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_duty
      assign fwd_duty[gi] = PW'(duty_frac(PWM_PERIOD, gi + 1, FWD_DUTY_DEN));
   end

   // crash_q asserts one edge after the count saturates with is_crash still high.
   always_ff @(posedge clk) begin
      if (reset || !bus.is_crash) begin
         filt_reg    <= '0;
         crash_q_reg <= 1'b0;
      end else begin
         if (filt_reg != FILT_MAX) begin
            filt_reg <= filt_reg + 1'b1;
         end
         crash_q_reg <= (filt_reg == FILT_MAX);
      end
   end

   assign dwell_done = (dwell_reg == '0);

   always_comb begin
      state_next = state_reg;
      retry_next = retry_reg;
      dwell_next = dwell_done ? '0 : dwell_reg - 1'b1;
      brake_req  = 1'b0;
      case (state_reg)
         S_IDLE:     if (!fault_reg) state_next = S_FWD;
         S_FWD:      brake_req = crash_q_reg;
         S_BRAKE:    if (dwell_done) begin
                        state_next = S_REV;
                        dwell_next = REV_LOAD;
                     end
         S_REV:      if (dwell_done) begin
                        state_next = S_TURN2BRK;
                        dwell_next = BRAKE_LOAD;
                     end
         S_TURN2BRK: if (dwell_done) begin
                        state_next = S_TURN;
                        dwell_next = TURN_LOAD;
                     end
         S_TURN:     if (dwell_done) begin
                        if (crash_q_reg) begin
                           brake_req = 1'b1;
                        end else begin
                           state_next = S_FWD;
                           retry_next = '0;
                        end
                     end
         S_FAULT:    state_next = S_FAULT;
         default:    state_next = S_IDLE;
      endcase
      if (brake_req) begin
         if (retry_reg >= RETRY_MAX) begin
            state_next = S_FAULT;
         end else begin
            state_next = S_BRAKE;
            retry_next = retry_reg + 1'b1;
            dwell_next = BRAKE_LOAD;
         end
      end
      // The run switch overrides everything; retry survives unless leaving FAULT.
      if (!bus.enable) begin
         state_next = S_IDLE;
         dwell_next = '0;
         if (state_reg == S_FAULT) retry_next = '0;
      end
   end

   always_comb begin
      pins_next = 4'b0000;
      case (state_next)
         S_FWD:               pins_next = 4'b1010;
         S_BRAKE, S_TURN2BRK: pins_next = 4'b1111;
         S_REV:               pins_next = 4'b0101;
         S_TURN:              pins_next = 4'b1001;
         default:             pins_next = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         dwell_reg <= '0;
         retry_reg <= '0;
         pins_reg  <= '0;
         led_reg   <= LED_IDLE;
         fault_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dwell_reg <= dwell_next;
         retry_reg <= retry_next;
         pins_reg  <= pins_next;
         led_reg   <= state_led_of(state_next);
         fault_reg <= (state_next == S_FAULT);
      end
   end

   assign braking  = (state_reg == S_BRAKE) || (state_reg == S_TURN2BRK);
   assign duty_sel = (braking || state_reg == S_REV || state_reg == S_TURN)
                   ? DUTY_HALF : fwd_duty[bus.speed_sel];
   assign duty_target = {duty_sel, duty_sel};
   assign pwm_active  = {2{state_reg inside {S_FWD, S_REV, S_TURN}}};

   pwm_gen #(
      .PERIOD (PWM_PERIOD),
      .CH     (2),
      .W      (PW)
   ) u_pwm (
      .clk    (clk),
      .srst   (reset),
      .target (duty_target),
      .active (pwm_active),
      .pwm    (pwm_raw)
   );

   assign bus.l_fwd     = pins_reg[3];
   assign bus.l_rev     = pins_reg[2];
   assign bus.r_fwd     = pins_reg[1];
   assign bus.r_rev     = pins_reg[0];
   assign bus.pwm_l     = braking | pwm_raw[0];
   assign bus.pwm_r     = braking | pwm_raw[1];
   assign bus.state_led = led_reg;
   assign bus.fault     = fault_reg;

endmodule

// File: tb/tb_rover_motor_ctrl.sv
// Directed bench for rover_motor_ctrl with shortened timing parameters.
module tb_rover_motor_ctrl;

   localparam int P = 20;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;
   int   phase       = 0;

   always #5 clk = ~clk;

   rover_motor_ctrl_if bus ();

   rover_motor_ctrl #(
      .PWM_PERIOD     (P),
      .CRASH_FILT_CYC (4),
      .BRAKE_CYC      (5),
      .REV_CYC        (10),
      .TURN_CYC       (8),
      .MAX_RETRY      (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [3:0] pins();
      return {bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; phase tracks position within the PWM frame once synced.
   task automatic step();
      @(negedge clk);
      phase = (phase + 1) % P;
      check("deadtime", 32'((bus.l_fwd & bus.l_rev) | (bus.r_fwd & bus.r_rev)),
            32'(bus.state_led == 3'd2));
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " led"},   32'(bus.state_led), 32'd0);
      check({tag, " pins"},  32'(pins()),        32'd0);
      check({tag, " pwm_l"}, 32'(bus.pwm_l),     32'd0);
      check({tag, " pwm_r"}, 32'(bus.pwm_r),     32'd0);
      check({tag, " fault"}, 32'(bus.fault),     32'd0);
   endtask

   // pmode: 0 = no PWM check, 1 = forced high, 2 = 50% against tracked phase
   task automatic run_state(input string tag, input int n, input logic [2:0] led,
                            input logic [3:0] pv, input int pmode);
      for (int i = 0; i < n; i++) begin
         check({tag, " led"},  32'(bus.state_led), 32'(led));
         check({tag, " pins"}, 32'(pins()),        32'(pv));
         if (pmode == 1) begin
            check({tag, " pwm_l"}, 32'(bus.pwm_l), 32'd1);
            check({tag, " pwm_r"}, 32'(bus.pwm_r), 32'd1);
         end else if (pmode == 2) begin
            check({tag, " pwm_l"}, 32'(bus.pwm_l), 32'(phase < P / 2));
            check({tag, " pwm_r"}, 32'(bus.pwm_r), 32'(phase < P / 2));
         end
         step();
      end
   endtask

   task automatic escape_loop(input string tag, input int rev_n, input int turn_n);
      run_state({tag, " brake"}, 5, 3'd2, 4'b1111, 1);
      run_state({tag, " rev"}, rev_n, 3'd3, 4'b0101, 2);
      if (rev_n == 10) begin
         run_state({tag, " t2b"}, 5, 3'd2, 4'b1111, 1);
         run_state({tag, " turn"}, turn_n, 3'd4, 4'b1001, 2);
      end
   endtask

   initial begin
      int  hi_l, hi_r;
      logic prev, found;

      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.is_crash  = 1'b0;
      bus.speed_sel = 2'd1;
      repeat (3) step();
      check_quiet("reset");
      reset = 1'b0;
      step();
      check("idle led", 32'(bus.state_led), 32'd0);

      $display("scenario 1: forward cruise and duty change");
      bus.enable = 1'b1;
      step();
      check("fwd led",  32'(bus.state_led), 32'd1);
      check("fwd pins", 32'(pins()),        32'b1010);
      repeat (40) step();
      hi_l = 0; hi_r = 0;
      for (int i = 0; i < P; i++) begin
         hi_l += int'(bus.pwm_l);
         hi_r += int'(bus.pwm_r);
         step();
      end
      check("duty50 l", 32'(hi_l), 32'd10);
      check("duty50 r", 32'(hi_r), 32'd10);
      found = 1'b0;
      for (int i = 0; i < 2 * P && !found; i++) begin
         prev = bus.pwm_l;
         step();
         if (!prev && bus.pwm_l) found = 1'b1;
      end
      check("frame sync", 32'(found), 32'd1);
      phase = 0;
      hi_l = 0;
      for (int i = 0; i < P; i++) begin
         hi_l += int'(bus.pwm_l);
         if (i == 3) bus.speed_sel = 2'd0;
         step();
      end
      check("old frame duty", 32'(hi_l), 32'd10);
      hi_l = 0;
      for (int i = 0; i < P; i++) begin
         hi_l += int'(bus.pwm_l);
         step();
      end
      check("new frame duty", 32'(hi_l), 32'd5);
      bus.speed_sel = 2'd1;
      repeat (P) step();

      $display("scenario 2: crash filter");
      bus.is_crash = 1'b1;
      repeat (3) step();
      bus.is_crash = 1'b0;
      repeat (3) step();
      check("short pulse led", 32'(bus.state_led), 32'd1);
      bus.is_crash = 1'b1;
      repeat (5) step();
      check("pre-brake led", 32'(bus.state_led), 32'd1);
      step();
      bus.is_crash = 1'b0;

      $display("scenario 3: full escape");
      escape_loop("esc", 10, 8);
      check("resume led",  32'(bus.state_led), 32'd1);
      check("resume pins", 32'(pins()),        32'b1010);

      $display("scenario 4: repeated crash to fault");
      bus.is_crash = 1'b1;
      repeat (5) step();
      check("hold pre-brake led", 32'(bus.state_led), 32'd1);
      step();
      for (int k = 0; k < 3; k++) escape_loop("retry", 10, 8);
      check("fault led",   32'(bus.state_led), 32'd5);
      check("fault flag",  32'(bus.fault),     32'd1);
      check("fault pins",  32'(pins()),        32'd0);
      check("fault pwm_l", 32'(bus.pwm_l),     32'd0);
      repeat (3) step();
      check("fault held", 32'(bus.state_led), 32'd5);
      bus.is_crash = 1'b0;
      bus.enable   = 1'b0;
      step();
      check_quiet("fault clear");
      bus.enable = 1'b1;
      step();
      check("refwd led",  32'(bus.state_led), 32'd1);
      check("refwd pins", 32'(pins()),        32'b1010);
      repeat (8) step();
      check("refwd stays", 32'(bus.state_led), 32'd1);

      $display("scenario 5: enable drop mid-reverse");
      bus.is_crash = 1'b1;
      repeat (6) step();
      bus.is_crash = 1'b0;
      escape_loop("drop", 4, 0);
      bus.enable = 1'b0;
      step();
      check_quiet("enable drop");

      $display("scenario 6: reset mid-turn");
      bus.enable = 1'b1;
      step();
      check("s6 fwd led", 32'(bus.state_led), 32'd1);
      bus.is_crash = 1'b1;
      repeat (6) step();
      bus.is_crash = 1'b0;
      escape_loop("s6", 10, 3);
      check("s6 in turn", 32'(bus.state_led), 32'd4);
      reset = 1'b1;
      step();
      check_quiet("mid reset");
      reset = 1'b0;
      step();
      check("post reset led",  32'(bus.state_led), 32'd1);
      check("post reset pins", 32'(pins()),        32'b1010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
